mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Two-master Avalon-MM arbiter sharing the single memory slave between the CPU bus master (m0) and a secondary master (m1: program loader / DMA / testbench backdoor). It sits between `mips_cpu_bus` and the memory, parks ownership on the last master, and never abandons a transaction stalled by `waitrequest`. An optional lock lets one master hold the bus for a bounded number of back-to-back transactions, such as read-modify-write.

## Interface
- `MAX_HOLD`, 4: maximum consecutive completed transactions a locked owner keeps while the other master waits; must be ≥1.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `m0_address`, `m1_address` input 32: master byte address.
- `m0_read`, `m1_read` input 1: read request.
- `m0_write`, `m1_write` input 1: write request.
- `m0_writedata`, `m1_writedata` input 32: write data.
- `m0_byteenable`, `m1_byteenable` input 4: byte enables.
- `m0_lock`, `m1_lock` input 1: request to retain ownership after the current transaction.
- `m0_waitrequest`, `m1_waitrequest` output 1: stall to master.
- `m0_readdata`, `m1_readdata` output 32: read data, broadcast from `s_readdata`.
- `s_address` output 32, `s_read` output 1, `s_write` output 1, `s_writedata` output 32, `s_byteenable` output 4: slave side.
- `s_waitrequest` input 1, `s_readdata` input 32: slave side.
- `owner` output 2: one-hot `{OWN1, OWN0}`; `00` = IDLE.

## Operation
- `req_i = mi_read | mi_write`. Read and write asserted together is illegal; the arbiter forwards it unchanged (no checking).
- States: IDLE, OWN0, OWN1.
- **IDLE:** `s_read = s_write = 0`, `s_address/writedata/byteenable = 0`; both waitrequests = 1. Next state: OWN0 if `req_0`, else OWN1 if `req_1`, else IDLE. On a tie m0 wins.
- **OWNi forwarding:**
  - `s_*` = `mi_*`.
  - `mi_waitrequest = s_waitrequest`.
  - Other master's waitrequest = 1.
  - `readdata` is broadcast to both masters.
- **Completion:** a cycle in OWNi with `req_i = 1` and `s_waitrequest = 0`.
- **In progress:** `req_i = 1` and `s_waitrequest = 1`. Ownership never changes on such an edge.
- **Boundary:** a cycle where OWNi is not in progress.
- **Switch rule:** at a boundary edge, move OWNi→OWNj iff `req_j = 1` and lock is not holding. Otherwise stay in OWNi (parked), including when nobody requests. IDLE is re-entered only via reset.
- **Hold counter:**
  - Width `$clog2(MAX_HOLD+1)`.
  - Increments on each completion by the current owner; saturates at `MAX_HOLD`.
  - Cleared to 0 on every ownership change.
- **Lock holding:** `mi_lock = 1` and (`hold_cnt` after this cycle's update) `< MAX_HOLD`.
- **Starved master:** its request is held stalled (`waitrequest = 1`) indefinitely. Avalon requires it to keep its signals stable; the arbiter does not sample them.

## Timing
- **Reset:**
  - state IDLE, `owner = 00`, `hold_cnt = 0`.
  - `s_read = s_write = 0`, `m0_waitrequest = m1_waitrequest = 1`.
- **Reset mid-transaction:** the slave request drops the next cycle. The stalled master sees `waitrequest = 1` throughout.
- **Grant latency from IDLE:** request at cycle N → `owner` and slave request at cycle N+1. Earliest completion is N+1.
- **Parked owner:** zero added latency. Master signals reach `s_*` combinationally the same cycle.
- **Switch latency:** boundary at cycle N with `req_j` → mj forwarded in cycle N+1.
- **Combinational paths:**
  - `mi_*` → `s_*`.
  - `s_waitrequest` → `mi_waitrequest`.
  - `s_readdata` → `mi_readdata`.
  - `owner` is registered.
- **Simultaneous events:**
  - Owner completes and other requests at the same edge → switch (unless lock holding).
  - Owner not requesting, other requesting → switch at that edge.

## Configuration
- `ARB_LOCK_EN` defined:
  - `mi_lock` and `MAX_HOLD` are honoured.
  - The hold counter is instantiated.
- `ARB_LOCK_EN` undefined:
  - Lock ports are present but ignored.
  - No hold counter.
  - Ownership switches at every boundary where the other master requests (strict alternation under contention).

## Test plan
- **Reset and first grant:** reset, then `m0_read = 1` at `0x00000010` → `owner = 01` next cycle, `s_read = 1`, `s_address = 0x10`; `m0_readdata` equals slave data on the cycle `s_waitrequest = 0`.
- **Tie from IDLE:** both request in the same cycle → `owner = 01`. After m0 completes, `owner = 10` the next cycle; `m1_waitrequest` is 1 until then.
- **No abandonment:** m1 requests while m0's write is stalled 3 cycles by `s_waitrequest` → `owner` stays `01` for all 3 cycles; switch only after the completing cycle; m0's `s_write` is never dropped early.
- **Lock bound (`ARB_LOCK_EN`, `MAX_HOLD = 4`):** `m0_lock = 1` with back-to-back reads while m1 requests → exactly 4 m0 completions, then `owner = 10`, `hold_cnt` back to 0.
- **Lock disabled (`ARB_LOCK_EN` undefined):** same stimulus → ownership alternates after every single completion.
- **Reset mid-transaction:** m1 write stalled, reset asserted → next cycle `owner = 00`, `s_write = 0`, both waitrequests = 1.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single memory slave; ownership parks on the last master.
// Define ARB_LOCK_EN to honour mX_lock with a MAX_HOLD-bounded hold counter.
module mips_bus_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_lock,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_lock,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  owner
);

  // State encoding doubles as the one-hot owner output.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t state_q, state_d;
  logic   req0, req1, cur_req, oth_req, in_progress, completion, lock_hold;

  assign req0        = m0_read | m0_write;
  assign req1        = m1_read | m1_write;
  assign owner       = state_q;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_req = 1'b0;
    oth_req = 1'b0;
    case (state_q)
      OWN0:    begin cur_req = req0; oth_req = req1; end
      OWN1:    begin cur_req = req1; oth_req = req0; end
      default: ;
    endcase
  end

  assign in_progress = cur_req & s_waitrequest;
  assign completion  = cur_req & ~s_waitrequest;

`ifdef ARB_LOCK_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_upd;
  logic          cur_lock;

  always_comb begin
    cur_lock = 1'b0;
    case (state_q)
      OWN0:    cur_lock = m0_lock;
      OWN1:    cur_lock = m1_lock;
      default: ;
    endcase
  end

  // Lock decision uses the count including this cycle's completion.
  always_comb begin
    hold_upd = hold_cnt_q;
    if (completion && hold_cnt_q != HW'(MAX_HOLD))
      hold_upd = hold_cnt_q + 1'b1;
  end

  assign lock_hold  = cur_lock && (hold_upd < HW'(MAX_HOLD));
  assign hold_cnt_d = (state_d != state_q) ? '0 : hold_upd;

  always_ff @(posedge clk) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  localparam int unused_max_hold = MAX_HOLD;
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign lock_hold   = 1'b0;
`endif

  // Ownership only moves at a boundary; an in-progress transfer is never abandoned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0)      state_d = OWN0;
        else if (req1) state_d = OWN1;
      end
      OWN0:    if (!in_progress && oth_req && !lock_hold) state_d = OWN1;
      OWN1:    if (!in_progress && oth_req && !lock_hold) state_d = OWN0;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: reset, grant, tie, no-abandon, lock bound, reset mid-transfer.
module tb_mips_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  owner;

  int vectors = 0;
  int miscompares = 0;

`ifdef ARB_LOCK_EN
  localparam int EXP_DONE = 4;
`else
  localparam int EXP_DONE = 1;
`endif

  mips_bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0; m0_lock = 0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0; m1_lock = 0;
    s_waitrequest = 0; s_readdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL reset_owner got %b want 00", owner); end
    vectors++; if (s_read !== 1'b0 || s_write !== 1'b0) begin miscompares++; $display("FAIL reset_sreq got r%b w%b want 0 0", s_read, s_write); end
    vectors++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL reset_wait got %b%b want 11", m0_waitrequest, m1_waitrequest); end
  endtask

  task automatic test_first_grant();
    m0_read = 1; m0_address = 32'h0000_0010; m0_byteenable = 4'hF;
    #1;
    vectors++; if (s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL idle_hold got s_read %b wait %b want 0 1", s_read, m0_waitrequest); end
    tick();
    s_readdata = 32'hCAFE_F00D;
    #1;
    vectors++; if (owner !== 2'b01) begin miscompares++; $display("FAIL grant_owner got %b want 01", owner); end
    vectors++; if (s_read !== 1'b1 || s_address !== 32'h10) begin miscompares++; $display("FAIL grant_fwd got r%b a%h want 1 00000010", s_read, s_address); end
    vectors++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL grant_data got w%b d%h want 0 cafef00d", m0_waitrequest, m0_readdata); end
    vectors++; if (m1_readdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL bcast_data got %h want cafef00d", m1_readdata); end
    tick();
    m0_read = 0;
    tick();
    vectors++; if (owner !== 2'b01 || s_read !== 1'b0) begin miscompares++; $display("FAIL parked got owner %b s_read %b want 01 0", owner, s_read); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_read = 1; m0_address = 32'h100;
    m1_write = 1; m1_address = 32'h200; m1_writedata = 32'h1234_5678; m1_byteenable = 4'h3;
    tick();
    vectors++; if (owner !== 2'b01 || m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b0) begin miscompares++; $display("FAIL tie_grant got owner %b w0 %b w1 %b want 01 0 1", owner, m0_waitrequest, m1_waitrequest); end
    tick();
    m0_read = 0;
    #1;
    vectors++; if (owner !== 2'b10 || s_write !== 1'b1 || s_address !== 32'h200) begin miscompares++; $display("FAIL tie_switch got owner %b w%b a%h want 10 1 00000200", owner, s_write, s_address); end
    vectors++; if (s_writedata !== 32'h1234_5678 || s_byteenable !== 4'h3 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL tie_fwd got d%h be%h w1 %b w0 %b want 12345678 3 0 1", s_writedata, s_byteenable, m1_waitrequest, m0_waitrequest); end
  endtask

  task automatic test_no_abandon();
    // m1 owns from the tie test; it drops, m0 takes over with a write.
    m1_write = 0;
    m0_write = 1; m0_address = 32'h300; m0_writedata = 32'hA5A5_0001;
    s_waitrequest = 1;
    tick();
    m1_read = 1; m1_address = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (owner !== 2'b01 || s_write !== 1'b1 || s_address !== 32'h300) begin miscompares++; $display("FAIL stall_%0d got owner %b w%b a%h want 01 1 00000300", i, owner, s_write, s_address); end
      vectors++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL stall_wait_%0d got %b%b want 11", i, m0_waitrequest, m1_waitrequest); end
      tick();
    end
    s_waitrequest = 0;
    #1;
    vectors++; if (owner !== 2'b01 || m0_waitrequest !== 1'b0 || s_write !== 1'b1) begin miscompares++; $display("FAIL complete got owner %b w0 %b s_write %b want 01 0 1", owner, m0_waitrequest, s_write); end
    tick();
    m0_write = 0;
    #1;
    vectors++; if (owner !== 2'b10 || s_read !== 1'b1 || s_address !== 32'h400) begin miscompares++; $display("FAIL after_stall got owner %b r%b a%h want 10 1 00000400", owner, s_read, s_address); end
  endtask

  task automatic test_lock_bound();
    int done = 0;
    bit switched = 0;
    do_reset();
    m0_lock = 1; m0_read = 1; m0_address = 32'h500;
    m1_read = 1; m1_address = 32'h600;
    tick();
    for (int i = 0; i < 12 && !switched; i++) begin
      if (owner === 2'b10) switched = 1;
      else begin
        if (owner === 2'b01 && m0_waitrequest === 1'b0) done++;
        tick();
      end
    end
    vectors++; if (!switched) begin miscompares++; $display("FAIL lock_switch got owner %b want 10 within 12 cycles", owner); end
    vectors++; if (done !== EXP_DONE) begin miscompares++; $display("FAIL lock_count got %0d want %0d", done, EXP_DONE); end
`ifdef ARB_LOCK_EN
    vectors++; if (dut.hold_cnt_q !== '0) begin miscompares++; $display("FAIL hold_clear got %0d want 0", dut.hold_cnt_q); end
`endif
    // m1 holds no lock, so it yields after a single completion.
    tick();
    vectors++; if (owner !== 2'b01) begin miscompares++; $display("FAIL alternate got %b want 01", owner); end
    m0_lock = 0;
    tick();
    vectors++; if (owner !== 2'b10) begin miscompares++; $display("FAIL alternate2 got %b want 10", owner); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_write = 1; m1_address = 32'h700; s_waitrequest = 1;
    tick();
    vectors++; if (owner !== 2'b10 || s_write !== 1'b1 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL mid_setup got owner %b w%b wait %b want 10 1 1", owner, s_write, m1_waitrequest); end
    reset = 1;
    tick();
    vectors++; if (owner !== 2'b00 || s_write !== 1'b0) begin miscompares++; $display("FAIL mid_reset got owner %b s_write %b want 00 0", owner, s_write); end
    vectors++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL mid_wait got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    reset = 0;
    tick();
    vectors++; if (owner !== 2'b10) begin miscompares++; $display("FAIL mid_regrant got %b want 10", owner); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    #2;
    test_reset();
    test_first_grant();
    test_tie();
    test_no_abandon();
    test_lock_bound();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
